// File: rtl/wb_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_arbiter2
// Purpose  : Two-master to one-slave arbiter for pipelined Wishbone
//            (stall/ack/err). Round-robin grant, held for the owner's whole
//            cycle and until every accepted transfer has been answered.
//            Outstanding transfers are counted so that responses always go
//            back to the master that issued them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   mN_cyc/stb/we           master N (N = 0,1) cycle, strobe, write enable
//   mN_adr/sel/dat_m        master N address, byte selects, write data
//   mN_dat_s                read data to master N (valid with mN_ack)
//   mN_ack/err/stall        response and flow control to master N
//   s_cyc/stb/we            slave cycle, strobe, write enable
//   s_adr/sel/dat_m         muxed request fields to slave
//   s_dat_s/ack/err/stall   slave read data, response and flow control
// ============================================================================
module wb_arbiter2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MAX_OUT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   // master 0
   input  logic            m0_cyc,
   input  logic            m0_stb,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_adr,
   input  logic [DW/8-1:0] m0_sel,
   input  logic [DW-1:0]   m0_dat_m,
   output logic [DW-1:0]   m0_dat_s,
   output logic            m0_ack,
   output logic            m0_err,
   output logic            m0_stall,
   // master 1
   input  logic            m1_cyc,
   input  logic            m1_stb,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_adr,
   input  logic [DW/8-1:0] m1_sel,
   input  logic [DW-1:0]   m1_dat_m,
   output logic [DW-1:0]   m1_dat_s,
   output logic            m1_ack,
   output logic            m1_err,
   output logic            m1_stall,
   // shared slave
   output logic            s_cyc,
   output logic            s_stb,
   output logic            s_we,
   output logic [AW-1:0]   s_adr,
   output logic [DW/8-1:0] s_sel,
   output logic [DW-1:0]   s_dat_m,
   input  logic [DW-1:0]   s_dat_s,
   input  logic            s_ack,
   input  logic            s_err,
   input  logic            s_stall
);

   // Counter must hold 0..MAX_OUT inclusive.
   localparam int                 c_cnt_w   = (MAX_OUT < 1) ? 1 : $clog2(MAX_OUT + 1);
   localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUT);
   localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_zero    = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_last;
   logic                 w_last_nxt;
   logic [c_cnt_w-1:0]   r_out_cnt;
   logic [c_cnt_w-1:0]   w_out_cnt_nxt;

   logic                 w_own0;
   logic                 w_own1;
   logic                 w_own_cyc;
   logic                 w_own_stb;
   logic                 w_room;
   logic                 w_full;
   logic                 w_busy;
   logic                 w_accept;
   logic                 w_resp;

   // ------------------------------------------------------------------------
   // Owner decode and outstanding-count flags
   // ------------------------------------------------------------------------
   assign w_own0    = (r_state == ST_OWN0);
   assign w_own1    = (r_state == ST_OWN1);
   assign w_own_cyc = (w_own0 & m0_cyc) | (w_own1 & m1_cyc);
   assign w_own_stb = (w_own0 & m0_stb) | (w_own1 & m1_stb);
   assign w_room    = (r_out_cnt < c_max_out);
   assign w_full    = (r_out_cnt == c_max_out);
   assign w_busy    = (r_out_cnt != c_zero);

   // ------------------------------------------------------------------------
   // Slave request path. s_cyc follows the owner's cyc combinationally so an
   // aborting master releases the slave in the very cycle it drops cyc.
   // Request fields are muxed by owner; their value outside a grant is
   // irrelevant because s_cyc is low then.
   // ------------------------------------------------------------------------
   assign s_cyc   = w_own_cyc;
   assign s_stb   = w_own_stb & w_room;
   assign s_we    = w_own1 ? m1_we    : m0_we;
   assign s_adr   = w_own1 ? m1_adr   : m0_adr;
   assign s_sel   = w_own1 ? m1_sel   : m0_sel;
   assign s_dat_m = w_own1 ? m1_dat_m : m0_dat_m;

   assign w_accept = s_cyc & s_stb & ~s_stall;
   // A response with nothing outstanding (late ack after an abort, stray ack)
   // is neither counted nor forwarded. ack+err together is one response.
   assign w_resp   = (s_ack | s_err) & w_busy;

   // ------------------------------------------------------------------------
   // Master response path. Read data is broadcast; ack/err qualify it.
   // Non-owners are always stalled and never see a response.
   // ------------------------------------------------------------------------
   assign m0_dat_s = s_dat_s;
   assign m1_dat_s = s_dat_s;

   assign m0_stall = ~w_own0 | s_stall | w_full;
   assign m1_stall = ~w_own1 | s_stall | w_full;

   assign m0_ack   = w_own0 & s_ack & w_busy;
   assign m0_err   = w_own0 & s_err & w_busy;
   assign m1_ack   = w_own1 & s_ack & w_busy;
   assign m1_err   = w_own1 & s_err & w_busy;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_last    <= 1'b1;       // m0 wins the first contended arbitration
         r_out_cnt <= c_zero;
      end else begin
         r_state   <= w_state_nxt;
         r_last    <= w_last_nxt;
         r_out_cnt <= w_out_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic: arbitration in IDLE, hold/release while owned,
   // outstanding-transfer accounting.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_last_nxt    = r_last;
      w_out_cnt_nxt = r_out_cnt;

      case (r_state)
         ST_IDLE: begin
            // Nothing can be outstanding here; the grant takes effect next
            // cycle, which gives the one-cycle arbitration latency.
            w_out_cnt_nxt = c_zero;
            if (m0_cyc && m1_cyc) begin
               w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
            end else if (m0_cyc) begin
               w_state_nxt = ST_OWN0;
            end else if (m1_cyc) begin
               w_state_nxt = ST_OWN1;
            end
         end

         ST_OWN0, ST_OWN1: begin
            if (!w_own_cyc) begin
               // Normal release (count already zero) or abort (count
               // non-zero): either way the slot is given up and any
               // remaining responses become orphans, dropped by the
               // zero-count rule.
               w_state_nxt   = ST_IDLE;
               w_last_nxt    = w_own1;
               w_out_cnt_nxt = c_zero;
            end else if (w_accept && !w_resp) begin
               if (r_out_cnt != c_max_out) begin
                  w_out_cnt_nxt = r_out_cnt + c_one;
               end
            end else if (w_resp && !w_accept) begin
               w_out_cnt_nxt = r_out_cnt - c_one;
            end
         end

         default: begin
            w_state_nxt   = ST_IDLE;
            w_out_cnt_nxt = c_zero;
         end
      endcase
   end

endmodule
`default_nettype wire
